// File: rtl/count_stream_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// count_stream_checker
//
// Downstream monitor for a WIDTH-bit enable-driven up-counter. Each rising
// clock edge it samples the counter output together with copies of the
// counter's own synchronous reset and enable inputs. It checks that every
// observed count equals the value implied by the previous edge's samples.
// It reports legal wrap-arounds and threshold entries as one-cycle pulses,
// flags illegal transitions with a sticky bit, and keeps saturating tallies.
//
// Parameters
//   WIDTH       width of the monitored count
//   WRAP_W      width of the wrap / mismatch tallies
//   THRESHOLD   count value that raises thr_hit on entry
//   STOP_ON_ERR 1: freeze in ERROR on first mismatch
//               0: log the mismatch, resync and keep tracking
//
// Ports
//   clk         system clock, rising-edge active
//   reset       asynchronous active-low reset
//   clear       synchronous clear of FSM, flags and tallies
//   cnt_in      monitored counter output
//   cnt_rst     copy of the counter's synchronous reset input
//   cnt_en      copy of the counter's enable input
//   wrap_pulse  one-cycle pulse after a legal MAX->0 increment
//   thr_hit     one-cycle pulse after the count enters THRESHOLD
//   mismatch    sticky illegal-transition flag
//   wrap_cnt    saturating wrap tally
//   err_cnt     saturating mismatch tally
//   state       FSM state: 00 IDLE, 01 TRACK, 10 ERROR
// -----------------------------------------------------------------------------
module count_stream_checker #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned WRAP_W      = 8,
    parameter int unsigned THRESHOLD   = 10,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              cnt_rst,
    input  logic              cnt_en,
    output logic              wrap_pulse,
    output logic              thr_hit,
    output logic              mismatch,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [WRAP_W-1:0] err_cnt,
    output logic [1:0]        state
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_TRACK = 2'b01;
    localparam logic [1:0] ST_ERROR = 2'b10;

    localparam logic [WIDTH-1:0]  CNT_MAX   = '1;
    localparam logic [WIDTH-1:0]  THR_VAL   = WIDTH'(THRESHOLD);
    localparam logic [WRAP_W-1:0] TALLY_MAX = '1;

    logic [1:0]        state_q,      state_d;
    logic [WIDTH-1:0]  prev_cnt_q,   prev_cnt_d;
    logic              prev_rst_q,   prev_rst_d;
    logic              prev_en_q,    prev_en_d;
    logic              wrap_pulse_q, wrap_pulse_d;
    logic              thr_hit_q,    thr_hit_d;
    logic              mismatch_q,   mismatch_d;
    logic [WRAP_W-1:0] wrap_cnt_q,   wrap_cnt_d;
    logic [WRAP_W-1:0] err_cnt_q,    err_cnt_d;

    logic [WIDTH-1:0]  expected;
    logic              legal;
    logic              is_wrap;
    logic              is_thr;
    logic [WRAP_W-1:0] wrap_cnt_inc;
    logic [WRAP_W-1:0] err_cnt_inc;

    // Value the counter must show now, given what it was told last edge.
    // The counter's reset dominates its enable.
    always_comb begin
        expected = prev_cnt_q;
        if (prev_rst_q) begin
            expected = '0;
        end else if (prev_en_q) begin
            expected = prev_cnt_q + WIDTH'(1);
        end
    end

    assign legal = (cnt_in == expected);

    // A reset-to-zero is not a wrap: only an enabled increment from MAX counts.
    assign is_wrap = !prev_rst_q && prev_en_q && (prev_cnt_q == CNT_MAX) && (cnt_in == '0);

    // Entry into THRESHOLD only; dwelling at THRESHOLD does not re-trigger.
    assign is_thr = (cnt_in == THR_VAL) && (prev_cnt_q != THR_VAL);

    assign wrap_cnt_inc = (wrap_cnt_q == TALLY_MAX) ? wrap_cnt_q : wrap_cnt_q + WRAP_W'(1);
    assign err_cnt_inc  = (err_cnt_q  == TALLY_MAX) ? err_cnt_q  : err_cnt_q  + WRAP_W'(1);

    always_comb begin
        state_d      = state_q;
        prev_cnt_d   = prev_cnt_q;
        prev_rst_d   = prev_rst_q;
        prev_en_d    = prev_en_q;
        wrap_pulse_d = 1'b0;
        thr_hit_d    = 1'b0;
        mismatch_d   = mismatch_q;
        wrap_cnt_d   = wrap_cnt_q;
        err_cnt_d    = err_cnt_q;

        if (clear) begin
            state_d    = ST_IDLE;
            prev_cnt_d = '0;
            prev_rst_d = 1'b0;
            prev_en_d  = 1'b0;
            mismatch_d = 1'b0;
            wrap_cnt_d = '0;
            err_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Seed the history; nothing to compare against yet.
                    prev_cnt_d = cnt_in;
                    prev_rst_d = cnt_rst;
                    prev_en_d  = cnt_en;
                    state_d    = ST_TRACK;
                end
                ST_TRACK: begin
                    // History always follows the observed value, so after a
                    // mismatch checking resumes from what was actually seen.
                    prev_cnt_d = cnt_in;
                    prev_rst_d = cnt_rst;
                    prev_en_d  = cnt_en;
                    if (legal) begin
                        wrap_pulse_d = is_wrap;
                        thr_hit_d    = is_thr;
                        if (is_wrap) begin
                            wrap_cnt_d = wrap_cnt_inc;
                        end
                    end else begin
                        mismatch_d = 1'b1;
                        err_cnt_d  = err_cnt_inc;
                        if (STOP_ON_ERR) begin
                            state_d = ST_ERROR;
                        end
                    end
                end
                ST_ERROR: begin
                    // Frozen: flags and tallies hold, pulses stay low.
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            prev_cnt_q   <= '0;
            prev_rst_q   <= 1'b0;
            prev_en_q    <= 1'b0;
            wrap_pulse_q <= 1'b0;
            thr_hit_q    <= 1'b0;
            mismatch_q   <= 1'b0;
            wrap_cnt_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_cnt_q   <= prev_cnt_d;
            prev_rst_q   <= prev_rst_d;
            prev_en_q    <= prev_en_d;
            wrap_pulse_q <= wrap_pulse_d;
            thr_hit_q    <= thr_hit_d;
            mismatch_q   <= mismatch_d;
            wrap_cnt_q   <= wrap_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign wrap_pulse = wrap_pulse_q;
    assign thr_hit    = thr_hit_q;
    assign mismatch   = mismatch_q;
    assign wrap_cnt   = wrap_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign state      = state_q;

endmodule

// File: tb/tb_count_stream_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_count_stream_checker
//
// Three checker instances share one stimulus stream:
//   d0: defaults (STOP_ON_ERR=0, WRAP_W=8)
//   d1: STOP_ON_ERR=1
//   d2: WRAP_W=2 (tallies saturate at 3)
// Every edge all instances are compared with a behavioural model; a vector
// table and hand-written sequences add hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_count_stream_checker;

    localparam int THR = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic [3:0] cnt_in;
    logic       cnt_rst;
    logic       cnt_en;

    always #5 clk = ~clk;

    logic       wp0, th0, mm0, wp1, th1, mm1, wp2, th2, mm2;
    logic [7:0] wc0, ec0, wc1, ec1;
    logic [1:0] wc2, ec2;
    logic [1:0] st0, st1, st2;

    count_stream_checker #(.WIDTH(4), .WRAP_W(8), .THRESHOLD(10), .STOP_ON_ERR(1'b0)) dut0 (
        .clk(clk), .reset(reset), .clear(clear), .cnt_in(cnt_in), .cnt_rst(cnt_rst),
        .cnt_en(cnt_en), .wrap_pulse(wp0), .thr_hit(th0), .mismatch(mm0),
        .wrap_cnt(wc0), .err_cnt(ec0), .state(st0));

    count_stream_checker #(.WIDTH(4), .WRAP_W(8), .THRESHOLD(10), .STOP_ON_ERR(1'b1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .cnt_in(cnt_in), .cnt_rst(cnt_rst),
        .cnt_en(cnt_en), .wrap_pulse(wp1), .thr_hit(th1), .mismatch(mm1),
        .wrap_cnt(wc1), .err_cnt(ec1), .state(st1));

    count_stream_checker #(.WIDTH(4), .WRAP_W(2), .THRESHOLD(10), .STOP_ON_ERR(1'b0)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .cnt_in(cnt_in), .cnt_rst(cnt_rst),
        .cnt_en(cnt_en), .wrap_pulse(wp2), .thr_hit(th2), .mismatch(mm2),
        .wrap_cnt(wc2), .err_cnt(ec2), .state(st2));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (one entry per instance) ------------
    // state: 0 idle, 1 tracking, 2 stopped
    int m_st[3], m_pc[3], m_pr[3], m_pe[3];
    int m_wp[3], m_th[3], m_mm[3], m_wc[3], m_ec[3];
    int m_stop[3] = '{0, 1, 0};
    int m_max[3]  = '{255, 255, 3};

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_pc[i] = 0; m_pr[i] = 0; m_pe[i] = 0;
            m_wp[i] = 0; m_th[i] = 0; m_mm[i] = 0; m_wc[i] = 0; m_ec[i] = 0;
        end
    endtask

    task automatic model_step(input logic clr, input logic [3:0] cin, input logic crst, input logic cen);
        for (int i = 0; i < 3; i++) begin
            int exp_v;
            m_wp[i] = 0;
            m_th[i] = 0;
            if (clr) begin
                m_st[i] = 0; m_mm[i] = 0; m_wc[i] = 0; m_ec[i] = 0;
            end else if (m_st[i] != 2) begin
                if (m_st[i] == 1) begin
                    if (m_pr[i] != 0)      exp_v = 0;
                    else if (m_pe[i] != 0) exp_v = (m_pc[i] + 1) % 16;
                    else                   exp_v = m_pc[i];
                    if (int'(cin) == exp_v) begin
                        if (m_pr[i] == 0 && m_pe[i] != 0 && m_pc[i] == 15) begin
                            m_wp[i] = 1;
                            if (m_wc[i] < m_max[i]) m_wc[i]++;
                        end
                        if (int'(cin) == THR && m_pc[i] != THR) m_th[i] = 1;
                    end else begin
                        m_mm[i] = 1;
                        if (m_ec[i] < m_max[i]) m_ec[i]++;
                        if (m_stop[i] != 0) m_st[i] = 2;
                    end
                end
                if (m_st[i] == 0) m_st[i] = 1;
                m_pc[i] = int'(cin);
                m_pr[i] = int'(crst);
                m_pe[i] = int'(cen);
            end
        end
    endtask

    task automatic cmp_inst(input int i, input logic [1:0] s, input logic wp, input logic th,
                            input logic mm, input logic [7:0] wc, input logic [7:0] ec);
        chk($sformatf("d%0d.state", i),      32'(s),  32'(m_st[i]));
        chk($sformatf("d%0d.wrap_pulse", i), 32'(wp), 32'(m_wp[i]));
        chk($sformatf("d%0d.thr_hit", i),    32'(th), 32'(m_th[i]));
        chk($sformatf("d%0d.mismatch", i),   32'(mm), 32'(m_mm[i]));
        chk($sformatf("d%0d.wrap_cnt", i),   32'(wc), 32'(m_wc[i]));
        chk($sformatf("d%0d.err_cnt", i),    32'(ec), 32'(m_ec[i]));
    endtask

    task automatic cmp_all();
        cmp_inst(0, st0, wp0, th0, mm0, wc0, ec0);
        cmp_inst(1, st1, wp1, th1, mm1, wc1, ec1);
        cmp_inst(2, st2, wp2, th2, mm2, {6'b0, wc2}, {6'b0, ec2});
    endtask

    task automatic step(input logic clr, input logic [3:0] cin, input logic crst, input logic cen);
        @(negedge clk);
        clear = clr; cnt_in = cin; cnt_rst = crst; cnt_en = cen;
        @(posedge clk);
        model_step(clr, cin, crst, cen);
        #1;
        cmp_all();
    endtask

    // Release reset between edges and take the first sample on the next edge.
    task automatic release_step(input logic [3:0] cin, input logic crst, input logic cen);
        @(negedge clk);
        reset = 1'b1;
        clear = 1'b0; cnt_in = cin; cnt_rst = crst; cnt_en = cen;
        @(posedge clk);
        model_step(1'b0, cin, crst, cen);
        #1;
        cmp_all();
    endtask

    // ---------------- vector table ------------------------------------------
    typedef struct {
        logic       clr;
        logic [3:0] cin;
        logic       crst;
        logic       cen;
        logic [1:0] s0;
        logic       th0;
        logic       mm0;
        logic [7:0] e0;
        logic [1:0] s1;
        logic       mm1;
        logic [7:0] e1;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nwrap, nthr, cnt;
        logic       r_clr, r_rst, r_en;
        logic [3:0] r_cin;

        //             clr   cin    rst   en    s0    th0   mm0   e0    s1    mm1   e1
        tbl[0] = '{1'b1, 4'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 4'd5,  1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 2'd1, 1'b0, 8'd0};
        tbl[2] = '{1'b0, 4'd9,  1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 8'd1, 2'd2, 1'b1, 8'd1};
        tbl[3] = '{1'b0, 4'd10, 1'b0, 1'b1, 2'd1, 1'b1, 1'b1, 8'd1, 2'd2, 1'b1, 8'd1};
        tbl[4] = '{1'b0, 4'd11, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 8'd1, 2'd2, 1'b1, 8'd1};
        tbl[5] = '{1'b0, 4'd3,  1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 8'd2, 2'd2, 1'b1, 8'd1};
        tbl[6] = '{1'b1, 4'd0,  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 8'd0};
        tbl[7] = '{1'b0, 4'd7,  1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 2'd1, 1'b0, 8'd0};
        tbl[8] = '{1'b0, 4'd8,  1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'd0, 2'd1, 1'b0, 8'd0};

        reset = 1'b0; clear = 1'b0; cnt_in = '0; cnt_rst = 1'b0; cnt_en = 1'b0;
        model_reset();
        #2;
        cmp_all();

        // Legal counting 0..39 with enable held: two wraps, two threshold hits.
        nwrap = 0; nthr = 0;
        release_step(4'd0, 1'b0, 1'b1);
        for (int k = 1; k < 40; k++) begin
            step(1'b0, 4'(k % 16), 1'b0, 1'b1);
            if (wp0) nwrap++;
            if (th0) nthr++;
        end
        chk("run40.wrap_pulses", 32'(nwrap), 32'd2);
        chk("run40.thr_pulses",  32'(nthr),  32'd2);
        chk("run40.wrap_cnt",    32'(wc0),   32'd2);
        chk("run40.mismatch",    32'(mm0),   32'd0);
        chk("run40.err_cnt",     32'(ec0),   32'd0);

        // Injection 5 -> 9, recovery, and freeze/clear on the stopping instance.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].clr, tbl[i].cin, tbl[i].crst, tbl[i].cen);
            chk($sformatf("tbl%0d.d0.state", i),   32'(st0), 32'(tbl[i].s0));
            chk($sformatf("tbl%0d.d0.thr_hit", i), 32'(th0), 32'(tbl[i].th0));
            chk($sformatf("tbl%0d.d0.mismatch", i),32'(mm0), 32'(tbl[i].mm0));
            chk($sformatf("tbl%0d.d0.err_cnt", i), 32'(ec0), 32'(tbl[i].e0));
            chk($sformatf("tbl%0d.d1.state", i),   32'(st1), 32'(tbl[i].s1));
            chk($sformatf("tbl%0d.d1.mismatch", i),32'(mm1), 32'(tbl[i].mm1));
            chk($sformatf("tbl%0d.d1.err_cnt", i), 32'(ec1), 32'(tbl[i].e1));
        end

        // Dwell at THRESHOLD: one pulse on entry only.
        step(1'b1, 4'd0, 1'b0, 1'b0);
        step(1'b0, 4'd8, 1'b0, 1'b1);
        step(1'b0, 4'd9, 1'b0, 1'b1);
        nthr = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 4'd10, 1'b0, 1'b0);
            if (th0) nthr++;
        end
        chk("dwell.thr_pulses", 32'(nthr), 32'd1);
        // Counter reset at 15 with enable high: 15 -> 0 is legal but not a wrap.
        step(1'b0, 4'd10, 1'b0, 1'b1);
        for (int k = 11; k < 15; k++) step(1'b0, 4'(k), 1'b0, 1'b1);
        step(1'b0, 4'd15, 1'b1, 1'b1);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        chk("rst15.wrap_pulse", 32'(wp0), 32'd0);
        chk("rst15.mismatch",   32'(mm0), 32'd0);
        chk("rst15.wrap_cnt",   32'(wc0), 32'd0);

        // Five wraps then five forced mismatches: narrow tallies saturate at 3.
        step(1'b1, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k <= 80; k++) step(1'b0, 4'(k % 16), 1'b0, 1'b1);
        chk("sat.d2.wrap_cnt", 32'(wc2), 32'd3);
        chk("sat.d0.wrap_cnt", 32'(wc0), 32'd5);
        for (int k = 1; k <= 5; k++) step(1'b0, 4'(2 * k), 1'b0, 1'b1);
        chk("sat.d2.err_cnt", 32'(ec2), 32'd3);
        chk("sat.d0.err_cnt", 32'(ec0), 32'd5);
        chk("sat.d0.state",   32'(st0), 32'd1);
        chk("sat.d1.state",   32'(st1), 32'd2);
        chk("sat.d1.err_cnt", 32'(ec1), 32'd1);

        // Asynchronous reset between edges while tracking with two wraps logged.
        step(1'b1, 4'd0, 1'b0, 1'b0);
        for (int k = 0; k < 34; k++) step(1'b0, 4'(k % 16), 1'b0, 1'b1);
        chk("areset.pre.wrap_cnt", 32'(wc0), 32'd2);
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        cmp_all();
        chk("areset.wrap_cnt", 32'(wc0), 32'd0);
        chk("areset.state",    32'(st0), 32'd0);
        release_step(4'd7, 1'b0, 1'b1);
        step(1'b0, 4'd8, 1'b0, 1'b1);
        chk("areset.post.mismatch", 32'(mm0), 32'd0);
        chk("areset.post.state",    32'(st0), 32'd1);

        // Randomised counter stream with occasional corruption and clears.
        cnt = 0;
        for (int n = 0; n < 1500; n++) begin
            r_rst = ($urandom_range(0, 29) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_clr = ($urandom_range(0, 59) == 0);
            r_cin = 4'(cnt);
            if ($urandom_range(0, 24) == 0) r_cin = 4'($urandom);
            step(r_clr, r_cin, r_rst, r_en);
            if (r_rst)     cnt = 0;
            else if (r_en) cnt = (cnt + 1) % 16;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_stream_checker.md
Name: count_stream_checker

Overview:
- Downstream monitor for the 4-bit enable-driven up-counter.
- Each clock it samples the counter output together with the counter's own reset and enable inputs, then checks that every count transition is legal.
- Reports wrap-around events, threshold crossings and mismatches; keeps saturating event tallies.
- Used in SoC bring-up and verification to flag counter corruption without a testbench scoreboard.

Parameters:
- WIDTH, 4, width of the monitored count.
- WRAP_W, 8, width of the wrap and mismatch tally counters.
- THRESHOLD, 10, count value that raises thr_hit on entry.
- STOP_ON_ERR, 0, 1 = freeze in ERROR on first mismatch; 0 = log the mismatch, resync and keep tracking.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear of FSM, flags and tallies.
- cnt_in  input  WIDTH  monitored counter output.
- cnt_rst  input  1  copy of the counter's synchronous reset input.
- cnt_en  input  1  copy of the counter's enable input.
- wrap_pulse  output  1  one-cycle pulse on a legal MAX->0 increment.
- thr_hit  output  1  one-cycle pulse when the count enters THRESHOLD.
- mismatch  output  1  sticky illegal-transition flag.
- wrap_cnt  output  WRAP_W  saturating wrap tally.
- err_cnt  output  WRAP_W  saturating mismatch tally.
- state  output  2  FSM state: 00 IDLE, 01 TRACK, 10 ERROR.

Behaviour:
- reset low (asynchronous): state=IDLE; wrap_pulse=0, thr_hit=0, mismatch=0, wrap_cnt=0, err_cnt=0; internal prev_cnt, prev_rst, prev_en all 0.
- Every edge outside IDLE/ERROR: prev_cnt, prev_rst and prev_en capture cnt_in, cnt_rst and cnt_en.
- Expected value at edge k, from the edge k-1 samples:
  - prev_rst=1 -> 0
  - else prev_en=1 -> (prev_cnt+1) mod 2^WIDTH
  - else -> prev_cnt
- cnt_rst has priority over cnt_en, matching the counter.
- IDLE:
  - First edge after reset release or clear captures the samples; no comparison is made.
  - Next state is TRACK.
- TRACK, every edge:
  - cnt_in == expected: legal transition.
  - cnt_in != expected: mismatch set (sticky); err_cnt incremented.
  - STOP_ON_ERR=1: go to ERROR.
  - STOP_ON_ERR=0: stay in TRACK; prev_cnt takes the observed cnt_in, so checking resynchronises.
- ERROR:
  - Holds all flags and tallies.
  - Pulses are forced to 0.
  - Captures no samples.
  - Leaves only via clear or reset.
- wrap_pulse:
  - Asserted for exactly one cycle after an edge where prev_rst=0, prev_en=1, prev_cnt=2^WIDTH-1 and cnt_in=0.
  - Only if that transition is legal.
  - wrap_cnt increments on the same edge.
  - A reset to 0 (prev_rst=1) is not a wrap.
- thr_hit:
  - Asserted for one cycle after an edge where cnt_in==THRESHOLD and prev_cnt!=THRESHOLD, in TRACK with a legal transition.
  - Holding at THRESHOLD does not re-pulse.
- Latency: all outputs registered; an event appears one clock after the edge that sampled the triggering cnt_in.
- Saturation: wrap_cnt and err_cnt stop at 2^WRAP_W-1 and never wrap to 0.
- Simultaneous events: wrap and mismatch are exclusive by construction. thr_hit and wrap_pulse coincide only if THRESHOLD=0; both pulse in that case.
- clear:
  - Synchronous.
  - Overrides all other activity: state=IDLE, flags and tallies=0, pulses=0.
  - Effective in any state.
  - Takes effect when asserted mid-ERROR or mid-pulse.
- reset mid-operation: immediate return to the reset values regardless of clock.
- First comparison after cnt_rst: the expected value is 0 irrespective of the enable sample.

Test Plan:
- Release reset, then drive cnt_en=1 and a legal counter model for 40 cycles from 0 -> wrap_pulse at cycles following 15->0 (twice); wrap_cnt=2; thr_hit twice; mismatch=0; err_cnt=0.
- Legal stream at 5, enable 1, then inject cnt_in=9 instead of 6 with STOP_ON_ERR=0 -> mismatch=1, err_cnt=1, state stays TRACK; a following legal 10 -> no further error and thr_hit pulses.
- Same injection with STOP_ON_ERR=1 -> state=ERROR. Subsequent stimulus is ignored and tallies are frozen. Pulse clear -> state IDLE, then TRACK, flags=0.
- Hold at 10 with cnt_en=0 for 5 cycles -> a single thr_hit on entry, no re-pulse. Assert cnt_rst at count 15 with cnt_en=1 -> cnt_in=0 is legal, wrap_pulse=0.
- WRAP_W=2 with 5 legal wraps -> wrap_cnt saturates at 3. 5 forced mismatches (STOP_ON_ERR=0) -> err_cnt=3.
- Assert reset asynchronously between edges while in TRACK with wrap_cnt=2 -> all outputs 0 immediately. After release, first edge gives IDLE->TRACK with no false mismatch.
